// File: rtl/ioctl_dispatch.sv
// ioctl_dispatch: routes hps_io ROM download bytes into per-region SDRAM words (toggle req/ack) and captures DIP-switch bytes.
// Latency: a byte lands in port_d/port_be 2 clocks after the ioctl_wr rising edge; port_req toggles 1 clock after the completing byte.
// Backpressure: IOCTL_DISPATCH_WAIT_EN defined -> ioctl_wait stalls hps_io until ack; undefined -> ioctl_wait tied 0, bytes needing a new word while busy are dropped and set err.
module ioctl_dispatch #(
    parameter int                        NUM_PORTS  = 2,
    parameter int                        DATA_BYTES = 2,
    parameter int                        ADDR_W     = 23,
    parameter logic [NUM_PORTS*25-1:0]   PORT_BASE  = {25'h10000, 25'h00000},
    parameter logic [NUM_PORTS*25-1:0]   PORT_SIZE  = {25'h0C000, 25'h10000},
    parameter int                        ROM_INDEX  = 0,
    parameter int                        DIP_INDEX  = 254,
    parameter int                        DIP_BYTES  = 8
) (
    input  logic                         clk_mem,
    input  logic                         reset_n,
    input  logic                         ioctl_download,
    input  logic                         ioctl_wr,
    input  logic [24:0]                  ioctl_addr,
    input  logic [7:0]                   ioctl_dout,
    input  logic [7:0]                   ioctl_index,
    output logic                         ioctl_wait,
    output logic [NUM_PORTS-1:0]         port_req,
    input  logic [NUM_PORTS-1:0]         port_ack,
    output logic [NUM_PORTS*ADDR_W-1:0]  port_a,
    output logic [DATA_BYTES*8-1:0]      port_d,
    output logic [DATA_BYTES-1:0]        port_be,
    output logic [DIP_BYTES*8-1:0]       dip_sw,
    output logic                         dl_done,
    output logic                         err
);

    localparam int LANE_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int PSEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int DIP_AW = (DIP_BYTES > 1) ? $clog2(DIP_BYTES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(DATA_BYTES - 1);

`ifdef IOCTL_DISPATCH_WAIT_EN
    // Busy-time bytes are parked in the hold slot; hps_io is stalled so it never overruns.
    localparam bit BUSY_HOLD = 1'b1;
`else
    // Busy-time bytes may only merge into the word already in flight.
    localparam bit BUSY_HOLD = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_ISSUE, S_WAIT_ACK} state_t;

    state_t                      r_state, w_nstate;

    logic                        r_wr_q, r_wr_qq, r_dl, r_rom_act_q;
    logic [24:0]                 r_addr;
    logic [7:0]                  r_dout, r_index;

    logic [DATA_BYTES*8-1:0]     r_d;
    logic [DATA_BYTES-1:0]       r_be;
    logic [PSEL_W-1:0]           r_port;
    logic [ADDR_W-1:0]           r_word;
    logic [NUM_PORTS-1:0]        r_req;
    logic [NUM_PORTS*ADDR_W-1:0] r_a;
    logic [DIP_BYTES*8-1:0]      r_dip;

    logic                        r_hold_vld;
    logic [PSEL_W-1:0]           r_hold_port;
    logic [ADDR_W-1:0]           r_hold_word;
    logic [LANE_W-1:0]           r_hold_lane;
    logic [7:0]                  r_hold_dat;

    logic                        r_end_pend, r_done, r_err;

    logic                        w_edge, w_rom_act, w_end, w_fin;
    logic                        w_hit, w_rom_hit, w_rom_miss;
    logic [PSEL_W-1:0]           w_port;
    logic [24:0]                 w_offset;
    logic [LANE_W-1:0]           w_lane;
    logic [ADDR_W-1:0]           w_word;
    logic [DATA_BYTES-1:0]       w_lane_bit, w_hold_bit;
    logic                        w_same_word, w_lane_free, w_acked;
    logic                        w_store, w_hold_set, w_load_hold, w_toggle, w_clr, w_done, w_err_set;

    // Input sampling: one register stage for the strobe edge detect and the byte that goes with it.
    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_q      <= 1'b0;
            r_wr_qq     <= 1'b0;
            r_dl        <= 1'b0;
            r_rom_act_q <= 1'b0;
            r_addr      <= '0;
            r_dout      <= '0;
            r_index     <= '0;
        end else begin
            r_wr_q      <= ioctl_wr;
            r_wr_qq     <= r_wr_q;
            r_dl        <= ioctl_download;
            r_rom_act_q <= w_rom_act;
            r_addr      <= ioctl_addr;
            r_dout      <= ioctl_dout;
            r_index     <= ioctl_index;
        end
    end

    assign w_edge     = r_wr_q & ~r_wr_qq;
    assign w_rom_act  = r_dl && (r_index == 8'(ROM_INDEX));
    // An index change counts as the end of the ROM session just like download falling.
    assign w_end      = r_rom_act_q & ~w_rom_act;
    assign w_fin      = w_end | r_end_pend;

    // Region decode: scan downwards so the lowest matching port wins.
    always_comb begin
        w_hit    = 1'b0;
        w_port   = '0;
        w_offset = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (({1'b0, r_addr} >= {1'b0, PORT_BASE[p*25 +: 25]}) &&
                ({1'b0, r_addr} <  ({1'b0, PORT_BASE[p*25 +: 25]} + {1'b0, PORT_SIZE[p*25 +: 25]}))) begin
                w_hit    = 1'b1;
                w_port   = PSEL_W'(p);
                w_offset = r_addr - PORT_BASE[p*25 +: 25];
            end
        end
    end

    assign w_lane      = LANE_W'(w_offset % DATA_BYTES);
    assign w_word      = ADDR_W'(w_offset / DATA_BYTES);
    assign w_lane_bit  = DATA_BYTES'(1) << w_lane;
    assign w_hold_bit  = DATA_BYTES'(1) << r_hold_lane;
    assign w_rom_hit   = w_edge & w_rom_act & w_hit;
    assign w_rom_miss  = w_edge & w_rom_act & ~w_hit;
    assign w_same_word = (r_be != '0) && (w_port == r_port) && (w_word == r_word);
    assign w_lane_free = ~r_be[w_lane];
    assign w_acked     = (r_state == S_WAIT_ACK) && (port_ack[r_port] == r_req[r_port]);

    // FSM state register.
    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_nstate;
    end

    // Next state and datapath controls.
    always_comb begin
        w_nstate    = r_state;
        w_store     = 1'b0;
        w_hold_set  = 1'b0;
        w_load_hold = 1'b0;
        w_toggle    = 1'b0;
        w_clr       = 1'b0;
        w_done      = 1'b0;
        w_err_set   = w_rom_miss;
        case (r_state)
            S_IDLE: begin
                if (w_rom_hit) begin
                    w_store  = 1'b1;
                    w_nstate = (w_lane == LAST_LANE) ? S_ISSUE : S_COLLECT;
                end else if (w_fin) begin
                    w_done = 1'b1;
                end
            end
            S_COLLECT: begin
                if (w_rom_hit && (r_be != '0) && !w_same_word) begin
                    // Flush the open word first; the new byte waits in the hold slot.
                    w_hold_set = 1'b1;
                    w_nstate   = S_ISSUE;
                end else if (w_rom_hit) begin
                    w_store = 1'b1;
                    if ((w_lane == LAST_LANE) || w_fin) w_nstate = S_ISSUE;
                end else if (w_fin) begin
                    if (r_be != '0) begin
                        w_nstate = S_ISSUE;
                    end else begin
                        w_nstate = S_IDLE;
                        w_done   = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                w_toggle = 1'b1;
                w_nstate = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (w_acked) begin
                    w_clr = 1'b1;
                    if (r_hold_vld) begin
                        w_load_hold = 1'b1;
                        w_nstate    = ((r_hold_lane == LAST_LANE) || w_fin) ? S_ISSUE : S_COLLECT;
                    end else if (w_rom_hit) begin
                        w_store  = 1'b1;
                        w_nstate = ((w_lane == LAST_LANE) || w_fin) ? S_ISSUE : S_COLLECT;
                    end else if (w_fin) begin
                        w_nstate = S_IDLE;
                        w_done   = 1'b1;
                    end else begin
                        w_nstate = S_COLLECT;
                    end
                end
            end
            default: w_nstate = S_IDLE;
        endcase
        // Bytes that arrive while a request is outstanding and were not taken above.
        if (((r_state == S_ISSUE) || (r_state == S_WAIT_ACK)) && w_rom_hit && !w_store) begin
            if (BUSY_HOLD && !r_hold_vld && !w_acked)
                w_hold_set = 1'b1;
            else if (!BUSY_HOLD && !w_acked && w_same_word && w_lane_free)
                w_store = 1'b1;
            else
                w_err_set = 1'b1;
        end
    end

    // Word assembly, hold slot, per-port request/address and status flags.
    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            r_d         <= '0;
            r_be        <= '0;
            r_port      <= '0;
            r_word      <= '0;
            r_req       <= '0;
            r_a         <= '0;
            r_hold_vld  <= 1'b0;
            r_hold_port <= '0;
            r_hold_word <= '0;
            r_hold_lane <= '0;
            r_hold_dat  <= '0;
            r_end_pend  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done     <= w_done;
            r_end_pend <= (r_end_pend | w_end) & ~w_done;
            if (w_err_set) r_err <= 1'b1;
            if (w_toggle) begin
                r_req[r_port]                 <= ~r_req[r_port];
                r_a[r_port*ADDR_W +: ADDR_W]  <= r_word;
            end
            if (w_hold_set) begin
                r_hold_vld  <= 1'b1;
                r_hold_port <= w_port;
                r_hold_word <= w_word;
                r_hold_lane <= w_lane;
                r_hold_dat  <= r_dout;
            end else if (w_load_hold) begin
                r_hold_vld  <= 1'b0;
            end
            if (w_load_hold) begin
                r_be                    <= w_hold_bit;
                r_d[r_hold_lane*8 +: 8] <= r_hold_dat;
                r_port                  <= r_hold_port;
                r_word                  <= r_hold_word;
            end else if (w_store) begin
                r_be               <= (w_clr ? '0 : r_be) | w_lane_bit;
                r_d[w_lane*8 +: 8] <= r_dout;
                r_port             <= w_port;
                r_word             <= w_word;
            end else if (w_clr) begin
                r_be <= '0;
            end
        end
    end

    // DIP-switch capture; independent of the ROM word path.
    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            r_dip <= '0;
        end else if (w_edge && (r_index == 8'(DIP_INDEX)) && (r_addr < 25'(DIP_BYTES))) begin
            r_dip[r_addr[DIP_AW-1:0]*8 +: 8] <= r_dout;
        end
    end

`ifdef IOCTL_DISPATCH_WAIT_EN
    logic r_wait;

    // Stall hps_io from the req toggle until the ack is seen.
    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) r_wait <= 1'b0;
        else          r_wait <= (w_nstate == S_WAIT_ACK);
    end

    assign ioctl_wait = r_wait;
`else
    assign ioctl_wait = 1'b0;
`endif

    assign port_req = r_req;
    assign port_a   = r_a;
    assign port_d   = r_d;
    assign port_be  = r_be;
    assign dip_sw   = r_dip;
    assign dl_done  = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_ioctl_dispatch.sv
module tb_ioctl_dispatch;

    localparam int NP = 2;
    localparam int DB = 2;
    localparam int AW = 23;
    localparam int DIPB = 8;
`ifdef IOCTL_DISPATCH_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic              clk_mem = 1'b0;
    logic              reset_n = 1'b0;
    logic              ioctl_download = 1'b0;
    logic              ioctl_wr = 1'b0;
    logic [24:0]       ioctl_addr = '0;
    logic [7:0]        ioctl_dout = '0;
    logic [7:0]        ioctl_index = '0;
    logic              ioctl_wait;
    logic [NP-1:0]     port_req;
    logic [NP-1:0]     port_ack = '0;
    logic [NP*AW-1:0]  port_a;
    logic [DB*8-1:0]   port_d;
    logic [DB-1:0]     port_be;
    logic [DIPB*8-1:0] dip_sw;
    logic              dl_done;
    logic              err;

    int checks = 0;
    int errors = 0;

    always #5 clk_mem = ~clk_mem;

    ioctl_dispatch dut (
        .clk_mem        (clk_mem),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_wait     (ioctl_wait),
        .port_req       (port_req),
        .port_ack       (port_ack),
        .port_a         (port_a),
        .port_d         (port_d),
        .port_be        (port_be),
        .dip_sw         (dip_sw),
        .dl_done        (dl_done),
        .err            (err)
    );

    // SDRAM-side model: byte-addressed memory image per port, random ack delay.
    logic [7:0]    mem [int];
    int            wr_cnt  [NP];
    logic [AW-1:0] last_a  [NP];
    logic [15:0]   last_d  [NP];
    logic [1:0]    last_be [NP];
    bit            busy    [NP];
    int            dly     [NP];
    int            done_cnt;
    bit            hold_ack = 1'b0;

    always @(negedge clk_mem) begin
        if (!reset_n) begin
            port_ack = '0;
            mem.delete();
            done_cnt = 0;
            for (int p = 0; p < NP; p++) begin
                busy[p] = 1'b0; wr_cnt[p] = 0; dly[p] = 0;
                last_a[p] = '0; last_d[p] = '0; last_be[p] = '0;
            end
        end else begin
            if (dl_done) done_cnt++;
            for (int p = 0; p < NP; p++) begin
                if (port_req[p] != port_ack[p]) begin
                    if (!busy[p]) begin
                        busy[p]    = 1'b1;
                        dly[p]     = $urandom_range(0, 3);
                        wr_cnt[p]++;
                        last_a[p]  = port_a[p*AW +: AW];
                        last_d[p]  = port_d;
                        last_be[p] = port_be;
                        for (int l = 0; l < DB; l++)
                            if (port_be[l]) mem[p*32'h100000 + int'(port_a[p*AW +: AW])*DB + l] = port_d[l*8 +: 8];
                    end else if (!hold_ack) begin
                        if (dly[p] == 0) begin
                            port_ack[p] = port_req[p];
                            busy[p]     = 1'b0;
                        end else begin
                            dly[p]--;
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_mem);
        reset_n = 1'b0; ioctl_wr = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0; hold_ack = 1'b0;
        repeat (3) @(negedge clk_mem);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_mem);
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        @(negedge clk_mem);
        ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
        repeat (2) @(negedge clk_mem);
        ioctl_wr = 1'b0;
        repeat (10) @(negedge clk_mem);
    endtask

    task automatic wait_done(input int n);
        for (int i = 0; i < 300 && done_cnt < n; i++) @(negedge clk_mem);
        chk("dl_done_count", 64'(done_cnt), 64'(n));
    endtask

    logic [7:0] exp_mem [int];
    bit         wset    [int];
    int         tot;

    initial begin
        // Reset held with strobes toggling: all outputs at reset values.
        ioctl_download = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_mem);
            ioctl_wr = ~ioctl_wr; ioctl_addr = 25'(i); ioctl_dout = 8'(8'h40 + i);
        end
        chk("rst_req",  64'(port_req), 0);
        chk("rst_a",    64'(port_a), 0);
        chk("rst_d",    64'(port_d), 0);
        chk("rst_be",   64'(port_be), 0);
        chk("rst_dip",  64'(dip_sw), 0);
        chk("rst_wait", 64'(ioctl_wait), 0);
        chk("rst_done", 64'(dl_done), 0);
        chk("rst_err",  64'(err), 0);
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        @(negedge clk_mem);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_mem);
        chk("rel_req", 64'(port_req), 0);

        // Two-port pack.
        do_reset();
        ioctl_download = 1'b1;
        send_byte(25'h00000, 8'hAA);
        send_byte(25'h00001, 8'hBB);
        send_byte(25'h10002, 8'hCC);
        send_byte(25'h10003, 8'hDD);
        ioctl_download = 1'b0;
        wait_done(1);
        chk("p0_cnt", 64'(wr_cnt[0]), 1);
        chk("p0_a",   64'(last_a[0]), 0);
        chk("p0_d",   64'(last_d[0]), 64'hBBAA);
        chk("p0_be",  64'(last_be[0]), 2'b11);
        chk("p1_cnt", 64'(wr_cnt[1]), 1);
        chk("p1_a",   64'(last_a[1]), 1);
        chk("p1_d",   64'(last_d[1]), 64'hDDCC);
        chk("p1_be",  64'(last_be[1]), 2'b11);
        chk("pack_err", 64'(err), 0);

        // Partial word with exact pipeline timing.
        do_reset();
        ioctl_download = 1'b1; hold_ack = 1'b1;
        @(negedge clk_mem);
        ioctl_addr = 25'h00005; ioctl_dout = 8'h55; ioctl_wr = 1'b1;
        @(posedge clk_mem); #1;
        chk("part_be_t1", 64'(port_be), 0);
        @(posedge clk_mem); #1;
        chk("part_be_t2", 64'(port_be), 2'b10);
        chk("part_d_t2",  64'(port_d[15:8]), 8'h55);
        chk("part_req_t2", 64'(port_req), 0);
        @(posedge clk_mem); #1;
        chk("part_req_t3", 64'(port_req), 2'b01);
        chk("part_a_t3",   64'(port_a[AW-1:0]), 2);
        chk("part_wait_t3", 64'(ioctl_wait), 64'(WAIT_EN));
        @(negedge clk_mem);
        ioctl_wr = 1'b0; hold_ack = 1'b0;
        for (int i = 0; i < 20 && port_be !== 2'b00; i++) @(negedge clk_mem);
        chk("part_be_clr", 64'(port_be), 0);
        chk("part_cnt", 64'(wr_cnt[0]), 1);
        chk("part_wa",  64'(last_a[0]), 2);
        chk("part_wbe", 64'(last_be[0]), 2'b10);
        chk("part_wd",  64'(last_d[0][15:8]), 8'h55);
        @(negedge clk_mem);
        ioctl_download = 1'b0;
        @(posedge clk_mem); #1;
        chk("done_t1", 64'(dl_done), 0);
        @(posedge clk_mem); #1;
        chk("done_t2", 64'(dl_done), 1);
        @(posedge clk_mem); #1;
        chk("done_t3", 64'(dl_done), 0);
        @(negedge clk_mem);
        chk("done_once", 64'(done_cnt), 1);

        // Ack held for 20 clocks with a new-word byte arriving meanwhile.
        do_reset();
        ioctl_download = 1'b1;
        send_byte(25'h00000, 8'hAA);
        hold_ack = 1'b1;
        send_byte(25'h00001, 8'hBB);
        chk("bp_req", 64'(port_req), 2'b01);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_mem);
            chk("bp_wait", 64'(ioctl_wait), 64'(WAIT_EN));
            if (i == 2) begin ioctl_addr = 25'h00002; ioctl_dout = 8'h11; ioctl_wr = 1'b1; end
            if (i == 4) ioctl_wr = 1'b0;
        end
        chk("bp_be_held", 64'(port_be), 2'b11);
        chk("bp_err", 64'(err), 64'(!WAIT_EN));
        hold_ack = 1'b0;
        for (int i = 0; i < 20 && port_be === 2'b11; i++) @(negedge clk_mem);
        chk("bp_be_after", 64'(port_be), WAIT_EN ? 64'h1 : 64'h0);
        chk("bp_d_after",  64'(port_d[7:0]), WAIT_EN ? 64'h11 : 64'hAA);
        // Asynchronous reset away from any clock edge.
        @(negedge clk_mem);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_req", 64'(port_req), 0);
        chk("arst_be",  64'(port_be), 0);
        chk("arst_d",   64'(port_d), 0);
        chk("arst_err", 64'(err), 0);

        // Out-of-region byte.
        do_reset();
        ioctl_download = 1'b1;
        send_byte(25'h1C000, 8'h77);
        chk("oor_err", 64'(err), 1);
        chk("oor_req", 64'(port_req), 0);
        chk("oor_be",  64'(port_be), 0);
        repeat (10) @(negedge clk_mem);
        ioctl_download = 1'b0;
        repeat (5) @(negedge clk_mem);
        chk("oor_sticky", 64'(err), 1);
        chk("oor_cnt", 64'(wr_cnt[0] + wr_cnt[1]), 0);

        // DIP capture.
        do_reset();
        ioctl_index = 8'd254; ioctl_download = 1'b1;
        send_byte(25'h00000, 8'h12);
        send_byte(25'h00001, 8'h34);
        send_byte(25'h00008, 8'h99);
        ioctl_download = 1'b0;
        repeat (5) @(negedge clk_mem);
        chk("dip_lo",  64'(dip_sw[15:0]), 64'h3412);
        chk("dip_hi",  64'(dip_sw[63:16]), 0);
        chk("dip_req", 64'(port_req), 0);
        chk("dip_done", 64'(done_cnt), 0);

        // Randomized downloads checked against a byte-level memory image.
        for (int t = 0; t < 6; t++) begin
            do_reset();
            exp_mem.delete();
            wset.delete();
            ioctl_download = 1'b1;
            for (int r = 0; r < int'($urandom_range(1, 3)); r++) begin
                int p, start, len;
                p     = $urandom_range(0, NP - 1);
                len   = $urandom_range(1, 7);
                start = r * 32'h1000 + $urandom_range(0, 255);
                for (int i = 0; i < len; i++) begin
                    logic [7:0] d;
                    d = 8'($urandom);
                    send_byte(25'((p == 0 ? 32'h00000 : 32'h10000) + start + i), d);
                    exp_mem[p*32'h100000 + start + i] = d;
                end
            end
            ioctl_download = 1'b0;
            wait_done(1);
            foreach (exp_mem[k]) wset[k / DB] = 1'b1;
            tot = wr_cnt[0] + wr_cnt[1];
            chk("rnd_writes", 64'(tot), 64'(wset.num()));
            chk("rnd_bytes",  64'(mem.num()), 64'(exp_mem.num()));
            foreach (exp_mem[k])
                chk("rnd_byte", mem.exists(k) ? 64'(mem[k]) : 64'hDEAD, 64'(exp_mem[k]));
            chk("rnd_err", 64'(err), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
